wavetable_nco_mc: RTL

//   Multi-channel, time-multiplexed numerically controlled oscillator. One phase accumulator per channel
//   and a single shared, writable wavetable. Per-channel waveform mode: table, saw, square or triangle.

---
 rtl/wavetable_nco_mc.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/wavetable_nco_mc.sv
// Time-multiplexed multi-channel NCO: per-channel phase accumulators sharing one writable wavetable,
// with table/saw/square/triangle shaping and one sample per channel streamed out per frame.
module wavetable_nco_mc #(
    parameter int NUM_CH   = 4,
    parameter int ACC_W    = 32,
    parameter int ADDR_W   = 10,
    parameter int SAMPLE_W = 16,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [ACC_W-1:0]    cfg_fcw,
    input  logic [1:0]          cfg_mode,
    input  logic                cfg_sync,
    input  logic                tbl_we,
    input  logic [ADDR_W-1:0]   tbl_addr,
    input  logic [SAMPLE_W-1:0] tbl_data,
    output logic                out_valid,
    output logic [CH_W-1:0]     out_ch,
    output logic [SAMPLE_W-1:0] out_sample,
    output logic                busy,
    output logic                overrun
);

    localparam int CNT_W = $clog2(NUM_CH + 1);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, RUN} state_t;

    typedef enum logic [1:0] {
        MODE_TABLE  = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_SQUARE = 2'd2,
        MODE_TRI    = 2'd3
    } mode_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               busy_r;
    logic               overrun_r;

    logic [ACC_W-1:0]   acc  [NUM_CH];
    logic [ACC_W-1:0]   fcw  [NUM_CH];
    logic [1:0]         mode [NUM_CH];

    logic signed [SAMPLE_W-1:0] mem [DEPTH];

    logic                       issue_p0;
    logic [CH_W-1:0]            ch_p0;
    logic [1:0]                 mode_p0;
    logic [SAMPLE_W:0]          top_p0;
    logic [ADDR_W-1:0]          addr_p0;
    logic signed [SAMPLE_W-1:0] shape_p0;

    logic                       vld_p1;
    logic [CH_W-1:0]            ch_p1;
    logic                       tbl_p1;
    logic signed [SAMPLE_W-1:0] shape_p1;
    logic signed [SAMPLE_W-1:0] rd_p1;

    function automatic logic signed [SAMPLE_W-1:0] saw_f(input logic m,
                                                         input logic [SAMPLE_W-2:0] hi);
        return $signed({~m, hi});
    endfunction

    function automatic logic signed [SAMPLE_W-1:0] square_f(input logic m);
        // Symmetric full-scale levels, avoiding the most negative code.
        return m ? $signed({1'b1, {(SAMPLE_W-2){1'b0}}, 1'b1})
                 : $signed({1'b0, {(SAMPLE_W-1){1'b1}}});
    endfunction

    function automatic logic signed [SAMPLE_W-1:0] tri_f(input logic m,
                                                         input logic [SAMPLE_W-1:0] lo);
        logic [SAMPLE_W-1:0] t;
        t = m ? ~lo : lo;
        return $signed({~t[SAMPLE_W-1], t[SAMPLE_W-2:0]});
    endfunction

    // Frame sequencer: NUM_CH issue cycles followed by one drain cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= tick && (state == RUN);
            case (state)
                IDLE: begin
                    if (tick) begin
                        state  <= RUN;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(NUM_CH)) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Stage p0: issue the current channel, read its phase before the update
    always_comb begin
        issue_p0 = (state == RUN) && (cnt < CNT_W'(NUM_CH));
        ch_p0    = cnt[CH_W-1:0];
        mode_p0  = mode[ch_p0];
        top_p0   = acc[ch_p0][ACC_W-1 -: SAMPLE_W+1];
        addr_p0  = acc[ch_p0][ACC_W-1 -: ADDR_W];
        shape_p0 = '0;
        case (mode_p0)
            MODE_SAW:    shape_p0 = saw_f(top_p0[SAMPLE_W], top_p0[SAMPLE_W-1:1]);
            MODE_SQUARE: shape_p0 = square_f(top_p0[SAMPLE_W]);
            MODE_TRI:    shape_p0 = tri_f(top_p0[SAMPLE_W], top_p0[SAMPLE_W-1:0]);
            default:     shape_p0 = '0;
        endcase
    end

    // Sync overrides the issue-cycle update; config writes land after the issue used the old values
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i]  <= '0;
                fcw[i]  <= '0;
                mode[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_sync && (cfg_ch == CH_W'(i))) begin
                    acc[i] <= '0;
                end else if (issue_p0 && (ch_p0 == CH_W'(i))) begin
                    acc[i] <= acc[i] + fcw[i];
                end
                if (cfg_we && (cfg_ch == CH_W'(i))) begin
                    fcw[i]  <= cfg_fcw;
                    mode[i] <= cfg_mode;
                end
            end
        end
    end

    // Wavetable: read-before-write on a same-address collision
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            mem[tbl_addr] <= tbl_data;
        end
        if (issue_p0) begin
            rd_p1 <= mem[addr_p0];
        end
    end

    // Stage p1: registered output, held between issues
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1   <= 1'b0;
            ch_p1    <= '0;
            tbl_p1   <= 1'b0;
            shape_p1 <= '0;
        end else begin
            vld_p1 <= issue_p0;
            if (issue_p0) begin
                ch_p1    <= ch_p0;
                tbl_p1   <= (mode_p0 == MODE_TABLE);
                shape_p1 <= shape_p0;
            end
        end
    end

    assign out_valid  = vld_p1;
    assign out_ch     = ch_p1;
    assign out_sample = tbl_p1 ? rd_p1 : shape_p1;
    assign busy       = busy_r;
    assign overrun    = overrun_r;

endmodule
